ddr_traffic_checker: RTL and testbench

- Synthesizable DDR traffic generator and checker. It sits between the board top and the user command port of the mobile-DDR controller.
- Writes a parametrised pattern over a word range, reads the range back with multiple reads outstanding, and compares against a regenerated pattern.
- Reports pass/fail, an error count and the first failing address. Replaces the bench-only 50 MHz clock/reset + model harness as the on-chip memory bring-up check.

---
 rtl/ddr_traffic_checker.sv | 226 ++++++++++++++++++++++
 tb/tb_ddr_traffic_checker.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_traffic_checker.sv
`default_nettype none
// ============================================================================
// Module   : ddr_traffic_checker
// Brief    : Writes a pattern over a word range on the DDR user port, reads it
//            back with several reads in flight and counts mismatching words.
//            Optional error injection: DDR_TRAFFIC_ERR_INJECT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ddr_traffic_checker #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 24,
    parameter int MAX_OUTST = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] num_words,
    input  logic [31:0]       seed,
`ifdef DDR_TRAFFIC_ERR_INJECT_EN
    input  logic              inj_en,
    input  logic [ADDR_W-1:0] inj_index,
`endif
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_we,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [DATA_W-1:0] cmd_wdata,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam logic [31:0]       C_LFSR_TAPS = 32'h8020_0003;
    localparam logic [DATA_W-1:0] C_ONE       = DATA_W'(1);
    localparam logic [3:0]        C_MAX_OUTST = 4'(MAX_OUTST);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR    = 3'd1,
        S_RD    = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [ADDR_W-1:0]  last_q, last_d;
    logic [31:0]        seed_q, seed_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [31:0]        lfsr_q, lfsr_d;
    logic [ADDR_W-1:0]  chk_idx_q, chk_idx_d;
    logic [31:0]        chk_lfsr_q, chk_lfsr_d;
    logic [3:0]         outst_q, outst_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [ADDR_W-1:0]  ferr_q, ferr_d;

    logic w_cmd_hs;
    logic w_rd_hs;
    logic w_rd_acc;
    logic w_inj_flip;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? C_LFSR_TAPS : 32'h0);
    endfunction

    function automatic logic [DATA_W-1:0] pattern(input logic [1:0]        m,
                                                   input logic [ADDR_W-1:0] i,
                                                   input logic [31:0]       l);
        logic [DATA_W-1:0] v;
        case (m)
            2'd0:    v = DATA_W'(i);
            2'd1:    v = {(DATA_W/32){l}};
            2'd2:    v = C_ONE << (32'(i) % 32'(DATA_W));
            default: v = ~DATA_W'(i);
        endcase
        return v;
    endfunction

`ifdef DDR_TRAFFIC_ERR_INJECT_EN
    logic              inj_q, inj_d;
    logic [ADDR_W-1:0] inj_idx_q, inj_idx_d;
    assign w_inj_flip = (state_q == S_WR) && inj_q && (idx_q == inj_idx_q);
`else
    assign w_inj_flip = 1'b0;
`endif

    assign cmd_we    = (state_q == S_WR);
    assign cmd_valid = (state_q == S_WR) || ((state_q == S_RD) && (outst_q < C_MAX_OUTST));
    assign cmd_addr  = base_q + idx_q;
    assign cmd_wdata = (state_q == S_WR) ? (pattern(mode_q, idx_q, lfsr_q) ^ DATA_W'(w_inj_flip))
                                         : '0;
    assign busy      = (state_q == S_WR) || (state_q == S_RD) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign pass      = done && (err_q == '0);
    assign err_count      = err_q;
    assign first_err_addr = ferr_q;

    assign w_cmd_hs = cmd_valid && cmd_ready;
    assign w_rd_hs  = w_cmd_hs && (state_q == S_RD);
    // Returns with nothing in flight belong to an aborted run and are dropped.
    assign w_rd_acc = rd_valid && (outst_q != 4'd0);

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        base_d     = base_q;
        last_d     = last_q;
        seed_d     = seed_q;
        idx_d      = idx_q;
        lfsr_d     = lfsr_q;
        chk_idx_d  = chk_idx_q;
        chk_lfsr_d = chk_lfsr_q;
        err_d      = err_q;
        ferr_d     = ferr_q;
`ifdef DDR_TRAFFIC_ERR_INJECT_EN
        inj_d      = inj_q;
        inj_idx_d  = inj_idx_q;
`endif

        case ({w_rd_hs, w_rd_acc})
            2'b10:   outst_d = outst_q + 4'd1;
            2'b01:   outst_d = outst_q - 4'd1;
            default: outst_d = outst_q;
        endcase

        if (w_rd_acc) begin
            chk_idx_d  = chk_idx_q + 1'b1;
            chk_lfsr_d = lfsr_next(chk_lfsr_q);
            if (rd_data != pattern(mode_q, chk_idx_q, chk_lfsr_q)) begin
                if (err_q != '1) err_d = err_q + 1'b1;
                if (err_q == '0) ferr_d = base_q + chk_idx_q;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_WR;
                    mode_d  = mode;
                    base_d  = base_addr;
                    last_d  = (num_words == '0) ? '0 : num_words - 1'b1;
                    seed_d  = (seed == 32'h0) ? 32'h1 : seed;
                    lfsr_d  = (seed == 32'h0) ? 32'h1 : seed;
                    idx_d   = '0;
                    err_d   = '0;
                    ferr_d  = '0;
`ifdef DDR_TRAFFIC_ERR_INJECT_EN
                    inj_d     = inj_en;
                    inj_idx_d = inj_index;
`endif
                end
            end
            S_WR: begin
                if (w_cmd_hs) begin
                    if (idx_q == last_q) begin
                        state_d    = S_RD;
                        idx_d      = '0;
                        chk_idx_d  = '0;
                        chk_lfsr_d = seed_q;
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        lfsr_d = lfsr_next(lfsr_q);
                    end
                end
            end
            S_RD: begin
                if (w_cmd_hs) begin
                    if (idx_q == last_q) state_d = S_DRAIN;
                    else                 idx_d   = idx_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (outst_d == 4'd0) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mode_q     <= '0;
            base_q     <= '0;
            last_q     <= '0;
            seed_q     <= '0;
            idx_q      <= '0;
            lfsr_q     <= '0;
            chk_idx_q  <= '0;
            chk_lfsr_q <= '0;
            outst_q    <= '0;
            err_q      <= '0;
            ferr_q     <= '0;
`ifdef DDR_TRAFFIC_ERR_INJECT_EN
            inj_q      <= 1'b0;
            inj_idx_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            base_q     <= base_d;
            last_q     <= last_d;
            seed_q     <= seed_d;
            idx_q      <= idx_d;
            lfsr_q     <= lfsr_d;
            chk_idx_q  <= chk_idx_d;
            chk_lfsr_q <= chk_lfsr_d;
            outst_q    <= outst_d;
            err_q      <= err_d;
            ferr_q     <= ferr_d;
`ifdef DDR_TRAFFIC_ERR_INJECT_EN
            inj_q      <= inj_d;
            inj_idx_q  <= inj_idx_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ddr_traffic_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_traffic_checker
// Brief    : Scoreboard bench for ddr_traffic_checker with a memory slave model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr_traffic_checker;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 24;
    localparam int MAX_OUTST = 4;
    localparam int CNT_W     = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] num_words;
    logic [31:0]       seed;
`ifdef DDR_TRAFFIC_ERR_INJECT_EN
    logic              inj_en;
    logic [ADDR_W-1:0] inj_index;
`endif
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic              pass;
    logic [CNT_W-1:0]  err_count;
    logic [ADDR_W-1:0] first_err_addr;

    ddr_traffic_checker #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_OUTST(MAX_OUTST), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .base_addr(base_addr), .num_words(num_words), .seed(seed),
`ifdef DDR_TRAFFIC_ERR_INJECT_EN
        .inj_en(inj_en), .inj_index(inj_index),
`endif
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_addr(first_err_addr)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic we; logic [ADDR_W-1:0] addr; logic [31:0] data; } cmd_t;
    typedef struct packed { logic [CNT_W-1:0] err; logic [ADDR_W-1:0] ferr; logic pass; } res_t;
    typedef struct packed { logic [31:0] due; logic [31:0] data; } ret_t;

    cmd_t exp_cmd[$];
    res_t exp_res[$];
    ret_t pend[$];
    logic [31:0] mem [logic [ADDR_W-1:0]];
    logic [31:0] corrupt [64];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int bout     = 0;
    int rd_num   = 0;
    int last_rv_cyc = -100;
    int lat_min  = 2;
    int lat_max  = 2;
    bit rand_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference pattern, straight from the pattern definitions.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    function automatic logic [31:0] pat(input logic [1:0] m, input int i, input logic [31:0] s);
        logic [31:0] x;
        case (m)
            2'd0: return 32'(i);
            2'd3: return ~32'(i);
            2'd2: return 32'h1 << (i % 32);
            default: begin
                x = (s == 32'h0) ? 32'h1 : s;
                for (int k = 0; k < i; k++) x = lfsr_step(x);
                return x;
            end
        endcase
    endfunction

    // Memory slave plus command-side monitor.
    logic              stalled = 1'b0;
    logic              st_we;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;
    initial begin
        cmd_ready = 1'b0;
        rd_valid  = 1'b0;
        rd_data   = '0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            cmd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            rd_valid  = 1'b0;
            rd_data   = $urandom;
            if (pend.size() > 0 && pend[0].due <= 32'(cyc)) begin
                rd_valid = 1'b1;
                rd_data  = pend[0].data;
                void'(pend.pop_front());
                if (!rst && bout > 0) begin
                    bout--;
                    last_rv_cyc = cyc;
                end
            end
            if (rst) bout = 0;
            if (stalled && !rst) begin
                check("stall_valid_held", cmd_valid, 1'b1);
                check("stall_we_stable", cmd_we, st_we);
                check("stall_addr_stable", cmd_addr, st_addr);
                check("stall_wdata_stable", cmd_wdata, st_data);
            end
            stalled = !rst && cmd_valid && !cmd_ready;
            st_we   = cmd_we;
            st_addr = cmd_addr;
            st_data = cmd_wdata;
            if (!rst && cmd_valid && cmd_ready) begin
                if (exp_cmd.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_cmd: got we=%0b addr=%0h, required no command", cmd_we, cmd_addr);
                end else begin
                    cmd_t e;
                    e = exp_cmd.pop_front();
                    check("cmd_we", cmd_we, e.we);
                    check("cmd_addr", cmd_addr, e.addr);
                    if (e.we) check("cmd_wdata", cmd_wdata, e.data);
                end
                if (cmd_we) begin
                    mem[cmd_addr] = cmd_wdata;
                end else begin
                    ret_t r;
                    check("outstanding_limit", 64'(bout < MAX_OUTST), 64'd1);
                    bout++;
                    r.due  = 32'(cyc + $urandom_range(lat_min, lat_max));
                    r.data = (mem.exists(cmd_addr) ? mem[cmd_addr] : 32'h0)
                             ^ ((rd_num < 64) ? corrupt[rd_num] : 32'h0);
                    pend.push_back(r);
                    rd_num++;
                end
            end
        end
    end

    // Result monitor: compares on every rising edge of done.
    logic done_prev = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (done && !done_prev && !rst) begin
                if (exp_res.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1, required no result");
                end else begin
                    res_t e;
                    e = exp_res.pop_front();
                    check("err_count", err_count, e.err);
                    check("first_err_addr", first_err_addr, e.ferr);
                    check("pass", pass, e.pass);
                    check("busy_at_done", busy, 1'b0);
                    check("done_latency", 64'(cyc), 64'(last_rv_cyc + 1));
                end
            end
            done_prev = done;
        end
    end

    task automatic start_test(input logic [1:0] m, input logic [ADDR_W-1:0] b,
                              input logic [ADDR_W-1:0] n, input logic [31:0] s,
                              input bit inj, input int inj_i);
        int nn;
        int nerr;
        logic [ADDR_W-1:0] ferr;
        logic [31:0] w;
        nn   = (n == '0) ? 1 : int'(n);
        nerr = 0;
        ferr = '0;
        for (int i = 0; i < nn; i++) begin
            w = pat(m, i, s) ^ ((inj && i == inj_i) ? 32'h1 : 32'h0);
            exp_cmd.push_back({1'b1, b + ADDR_W'(i), w});
            if ((w ^ corrupt[i]) != pat(m, i, s)) begin
                if (nerr == 0) ferr = b + ADDR_W'(i);
                nerr++;
            end
        end
        for (int i = 0; i < nn; i++) exp_cmd.push_back({1'b0, b + ADDR_W'(i), 32'h0});
        exp_res.push_back({CNT_W'(nerr), ferr, (nerr == 0)});

        @(negedge clk);
        start = 1'b1; mode = m; base_addr = b; num_words = n; seed = s;
`ifdef DDR_TRAFFIC_ERR_INJECT_EN
        inj_en = inj; inj_index = ADDR_W'(inj_i);
`endif
        rd_num = 0;
        @(negedge clk);
        start = 1'b0;
        mode = 2'($urandom); base_addr = ADDR_W'($urandom);
        num_words = ADDR_W'($urandom); seed = $urandom;
`ifdef DDR_TRAFFIC_ERR_INJECT_EN
        inj_en = 1'b0;
`endif
        #2;
        check("first_write_latency", {62'd0, cmd_valid, cmd_we}, 64'd3);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!done && k < 4000) begin
            @(negedge clk);
            #3;
            k++;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got done=0, required 1");
        end
        repeat (2) @(negedge clk);
        #3;
        check("sb_cmd_drained", 64'(exp_cmd.size()), 64'd0);
        check("sb_res_drained", 64'(exp_res.size()), 64'd0);
        check("done_held", done, 1'b1);
        exp_cmd.delete();
        exp_res.delete();
    endtask

    task automatic clear_corrupt();
        for (int i = 0; i < 64; i++) corrupt[i] = 32'h0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd_valid"}, cmd_valid, 1'b0);
        check({tag, "_cmd_we"}, cmd_we, 1'b0);
        check({tag, "_cmd_addr"}, cmd_addr, '0);
        check({tag, "_cmd_wdata"}, cmd_wdata, '0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_pass"}, pass, 1'b0);
        check({tag, "_err_count"}, err_count, '0);
        check({tag, "_first_err_addr"}, first_err_addr, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1; start = 1'b0; mode = '0; base_addr = '0; num_words = '0; seed = '0;
`ifdef DDR_TRAFFIC_ERR_INJECT_EN
        inj_en = 1'b0; inj_index = '0;
`endif
        clear_corrupt();
        repeat (3) @(negedge clk);
        #2;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;

        // Ideal slave, address pattern.
        start_test(2'd0, 24'h100, 24'd8, 32'h0, 1'b0, 0);
        wait_done();

        // LFSR from seed 0, random stalls and latency; a start while busy is ignored.
        rand_ready = 1'b1; lat_min = 1; lat_max = 6;
        start_test(2'd1, 24'h000, 24'd16, 32'h0, 1'b0, 0);
        repeat (4) @(negedge clk);
        start = 1'b1; mode = 2'd0; num_words = 24'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Walking one with two corrupted read words.
        corrupt[5] = 32'h8; corrupt[9] = 32'h1;
        start_test(2'd2, 24'h20, 24'd16, 32'h0, 1'b0, 0);
        wait_done();
        clear_corrupt();

        // Address wrap, inverted address pattern.
        start_test(2'd3, 24'hFFFFFE, 24'd4, 32'h0, 1'b0, 0);
        wait_done();

        // Abort mid-read with three reads in flight.
        rand_ready = 1'b0; lat_min = 6; lat_max = 6;
        start_test(2'd0, 24'h40, 24'd8, 32'h0, 1'b0, 0);
        k = 0;
        while (!(bout == 3 && busy && !cmd_we) && k < 200) begin
            @(negedge clk);
            #3;
            k++;
        end
        check("reached_3_outstanding", 64'(bout), 64'd3);
        @(negedge clk);
        rst = 1'b1;
        exp_cmd.delete();
        exp_res.delete();
        repeat (2) @(negedge clk);
        #2;
        check_reset_values("abort");
        rst = 1'b0;
        repeat (12) @(negedge clk);
        #2;
        check("stale_ignored_err", err_count, '0);
        check("stale_ignored_busy", {busy, done}, 2'b00);
        lat_min = 2; lat_max = 2;
        start_test(2'd0, 24'h300, 24'd0, 32'h0, 1'b0, 0);
        wait_done();

        // Randomized runs, optionally with one corrupted word.
        rand_ready = 1'b1; lat_min = 1; lat_max = 6;
        for (int r = 0; r < 5; r++) begin
            clear_corrupt();
            if ($urandom_range(0, 1) == 1) corrupt[$urandom_range(0, 19)] = $urandom | 32'h1;
            start_test(2'($urandom), ADDR_W'($urandom), ADDR_W'($urandom_range(1, 20)),
                       $urandom, 1'b0, 0);
            wait_done();
        end
        clear_corrupt();

`ifdef DDR_TRAFFIC_ERR_INJECT_EN
        rand_ready = 1'b0; lat_min = 2; lat_max = 2;
        start_test(2'd0, 24'h500, 24'd8, 32'h0, 1'b1, 3);
        wait_done();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
